// File: rtl/neuron_trainer.sv
// rtl/neuron_trainer.sv - perceptron trainer for a two-input Q4.4 step neuron
module neuron_trainer #(
    parameter logic signed [15:0] LR         = 16'sd16,
    parameter int                 MAX_EPOCHS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         target,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic signed [15:0] w1,
    output logic signed [15:0] w2,
    output logic signed [15:0] b,
    output logic [5:0]         epoch
);

    typedef enum logic [1:0] {IDLE, TRAIN, DONE} state_t;

    localparam logic [5:0] LAST_EPOCH = 6'(MAX_EPOCHS - 1);

    state_t             state_q, state_d;
    logic [3:0]         tgt_q, tgt_d;
    logic signed [15:0] w1_q, w1_d, w2_q, w2_d, b_q, b_d;
    logic [5:0]         epoch_q, epoch_d;
    logic [1:0]         idx_q, idx_d;
    logic               flag_q, flag_d;
    logic               conv_q, conv_d;

    logic               x1, x2, y, t, err_pos, err_neg, err_any;
    logic signed [17:0] w1_ext, w2_ext, b_ext, lr_ext, sum, step;
    logic signed [15:0] w1_upd, w2_upd, b_upd;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sd32767;
        else if (v < -18'sd32768)
            return -16'sd32768;
        else
            return v[15:0];
    endfunction

    // Forward pass and error for the sample selected by idx_q
    always_comb begin
        x1      = idx_q[1];
        x2      = idx_q[0];
        w1_ext  = {{2{w1_q[15]}}, w1_q};
        w2_ext  = {{2{w2_q[15]}}, w2_q};
        b_ext   = {{2{b_q[15]}}, b_q};
        lr_ext  = {{2{LR[15]}}, LR};
        sum     = (x1 ? w1_ext : 18'sd0) + (x2 ? w2_ext : 18'sd0) + b_ext;
        y       = (sum > 18'sd0);
        t       = tgt_q[idx_q];
        err_pos = t & ~y;
        err_neg = ~t & y;
        err_any = err_pos | err_neg;
        step    = err_pos ? lr_ext : (err_neg ? -lr_ext : 18'sd0);
        w1_upd  = x1 ? sat16(w1_ext + step) : w1_q;
        w2_upd  = x2 ? sat16(w2_ext + step) : w2_q;
        b_upd   = sat16(b_ext + step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= 4'd0;
            w1_q    <= 16'sd0;
            w2_q    <= 16'sd0;
            b_q     <= 16'sd0;
            epoch_q <= 6'd0;
            idx_q   <= 2'd0;
            flag_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            b_q     <= b_d;
            epoch_q <= epoch_d;
            idx_q   <= idx_d;
            flag_q  <= flag_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        b_d     = b_q;
        epoch_d = epoch_q;
        idx_d   = idx_q;
        flag_d  = flag_q;
        conv_d  = conv_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = TRAIN;
                    tgt_d   = target;
                    w1_d    = 16'sd0;
                    w2_d    = 16'sd0;
                    b_d     = 16'sd0;
                    epoch_d = 6'd0;
                    idx_d   = 2'd0;
                    flag_d  = 1'b0;
                    conv_d  = 1'b0;
                end
            end
            TRAIN: begin
                w1_d   = w1_upd;
                w2_d   = w2_upd;
                b_d    = b_upd;
                idx_d  = idx_q + 2'd1;
                flag_d = flag_q | err_any;
                // Epoch decision includes the error of the last sample itself
                if (idx_q == 2'd3) begin
                    if (!(flag_q | err_any)) begin
                        state_d = DONE;
                        conv_d  = 1'b1;
                    end else if (epoch_q == LAST_EPOCH) begin
                        state_d = DONE;
                        conv_d  = 1'b0;
                    end else begin
                        epoch_d = epoch_q + 6'd1;
                        flag_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == TRAIN);
        done      = (state_q == DONE);
        converged = conv_q;
        w1        = w1_q;
        w2        = w2_q;
        b         = b_q;
        epoch     = epoch_q;
    end

endmodule

// File: tb/tb_neuron_trainer.sv
// tb/tb_neuron_trainer.sv - directed scoreboard bench for neuron_trainer
module tb_neuron_trainer;

    localparam int MAXE = 32;

    logic               clk = 1'b0;
    logic               rst, start, start2;
    logic [3:0]         target, target2;
    logic               busy, done, converged, busy2, done2, conv2;
    logic signed [15:0] w1, w2, b, w1_2, w2_2, b_2;
    logic [5:0]         epoch, epoch2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic               conv;
        logic [5:0]         ep;
        logic signed [15:0] w1, w2, b;
        int                 cyc;
    } exp_t;
    exp_t        sb[$];
    logic [47:0] satq[$];

    int m_w1, m_w2, m_b, m_i, m_ep;
    bit m_flag, m_done, m_conv;

    neuron_trainer dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .busy(busy), .done(done), .converged(converged),
        .w1(w1), .w2(w2), .b(b), .epoch(epoch)
    );

    neuron_trainer #(.LR(16'sd16384), .MAX_EPOCHS(MAXE)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .target(target2),
        .busy(busy2), .done(done2), .converged(conv2),
        .w1(w1_2), .w2(w2_2), .b(b_2), .epoch(epoch2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic m_reset();
        m_w1 = 0; m_w2 = 0; m_b = 0; m_i = 0; m_ep = 0;
        m_flag = 0; m_done = 0; m_conv = 0;
    endtask

    task automatic m_step(input logic [3:0] tg, input int lr);
        int x1, x2, sum, y, t, err;
        x1  = (m_i >> 1) & 1;
        x2  = m_i & 1;
        sum = x1 * m_w1 + x2 * m_w2 + m_b;
        y   = (sum > 0) ? 1 : 0;
        t   = tg[m_i] ? 1 : 0;
        err = t - y;
        m_w1 = sat(m_w1 + err * lr * x1);
        m_w2 = sat(m_w2 + err * lr * x2);
        m_b  = sat(m_b + err * lr);
        if (err != 0) m_flag = 1;
        if (m_i == 3) begin
            if (!m_flag) begin
                m_done = 1;
                m_conv = 1;
            end else if (m_ep == MAXE - 1) begin
                m_done = 1;
            end else begin
                m_ep++;
                m_flag = 0;
            end
        end
        m_i = (m_i + 1) % 4;
    endtask

    // mode 1: pulse start mid-run, mode 2: change target mid-run
    task automatic run(input logic [3:0] tg, input int cyc, input logic cv,
                       input int ep, input int ew1, input int ew2, input int eb,
                       input int mode);
        exp_t e;
        int   k;
        int   busy_low;
        e.conv = cv; e.ep = 6'(ep); e.cyc = cyc;
        e.w1 = 16'(ew1); e.w2 = 16'(ew2); e.b = 16'(eb);
        sb.push_back(e);
        target = tg;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("conv_cleared", converged, 0);
        k = 0;
        busy_low = 0;
        while (!done && k < 300) begin
            if (mode == 1 && k == 5) start = 1'b1;
            if (mode == 2 && k == 5) target = ~tg;
            tick();
            start = 1'b0;
            k++;
            if (!done && !busy) busy_low++;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        chk("done_latency", k, e.cyc);
        chk("busy_at_done", busy, 0);
        chk("busy_throughout", busy_low, 0);
        chk("converged", converged, e.conv);
        chk("epoch", epoch, e.ep);
        chk("w1", w1, e.w1);
        chk("w2", w2, e.w2);
        chk("b", b, e.b);
        tick();
        chk("done_holds", done, 1);
        chk("weights_hold", {w1, w2, b}, {e.w1, e.w2, e.b});
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        target = 4'd0; target2 = 4'd0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", converged, 0);
        chk("rst_weights", {w1, w2, b}, 48'd0);
        chk("rst_epoch", epoch, 0);
        chk("rst_sat_state", {busy2, done2, conv2}, 3'b000);
        rst = 1'b0;
        tick();

        run(4'b1000, 24, 1'b1, 5, 32, 16, -32, 0);
        run(4'b1110, 16, 1'b1, 3, 16, 16, 0, 0);

        m_reset();
        while (!m_done) m_step(4'b0110, 16);
        run(4'b0110, 128, 1'b0, 31, m_w1, m_w2, m_b, 0);

        run(4'b1000, 24, 1'b1, 5, 32, 16, -32, 1);
        run(4'b1000, 24, 1'b1, 5, 32, 16, -32, 2);

        target = 4'b1000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (9) tick();
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_conv", converged, 0);
        chk("midrst_weights", {w1, w2, b}, 48'd0);
        chk("midrst_epoch", epoch, 0);
        tick();
        chk("idle_after_rst", {busy, done}, 2'b00);

        run(4'b1110, 16, 1'b1, 3, 16, 16, 0, 0);

        m_reset();
        target2 = 4'b0110;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
        n = 0;
        while (!m_done && n < 200) begin
            m_step(4'b0110, 16384);
            satq.push_back({16'(m_w1), 16'(m_w2), 16'(m_b)});
            tick();
            n++;
            chk("sat_weights", {w1_2, w2_2, b_2}, satq.pop_front());
        end
        chk("sat_cycles", n, 128);
        chk("sat_done", done2, 1);
        chk("sat_conv", conv2, 0);
        chk("sat_epoch", epoch2, 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_trainer.md
# neuron_trainer

Sequential perceptron trainer that learns the weights of a two-input step-activation neuron (Q4.4 signed fixed point, scale 16) for any 2-input boolean truth table. This is the learning-side counterpart of the fixed-weight inference neurons in the XOR ANN design. Its final weights (`w1`, `w2`, `b`) connect directly to the `W1`/`W2`/`B` values of a `neuron` instance. Non-linearly-separable targets such as XOR are reported as not converged.

## Interface

Parameters:
- `LR`, 16'sd16: learning rate in Q4.4 (16 = 1.0); added or subtracted per error.
- `MAX_EPOCHS`, 32: epoch limit before the trainer gives up; range 1..64.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin training; sampled only in IDLE or DONE.
- `target`, input, 4: truth table; `target[i]` is the desired output for `{x1,x2} = i`.
- `busy`, output, 1: high while in TRAIN.
- `done`, output, 1: high while in DONE.
- `converged`, output, 1: valid while `done`; 1 means a full epoch completed with zero errors.
- `w1`, output, 16 signed: current weight for `x1`, Q4.4.
- `w2`, output, 16 signed: current weight for `x2`, Q4.4.
- `b`, output, 16 signed: current bias, Q4.4.
- `epoch`, output, 6: index of the current epoch, or of the last epoch once done.

## Operation

- States: IDLE, TRAIN, DONE.
- Transitions:
  - IDLE→TRAIN on `start`.
  - DONE→TRAIN on `start`.
  - TRAIN→DONE at the end of an epoch, as defined below.
  - DONE otherwise holds.
- On an accepted `start`:
  - `target` is latched. Later changes to the `target` input have no effect until the next `start`.
  - `w1`, `w2`, `b` are cleared to 0; `epoch` and the sample index are cleared to 0; the error flag is cleared.
- TRAIN processes one sample per cycle, with sample index `i` running 0,1,2,3, where `x1 = i[1]` and `x2 = i[0]`.
  - Forward pass: `sum = w1·x1 + w2·x2 + b`, computed at 18-bit signed width so no overflow is possible.
  - Activation: `y = 1` iff `sum > 0`. A sum of exactly 0 gives `y = 0`.
  - Error: `err = t − y`, where `t = target[i]`.
  - Update on `err = +1`: `w1 += LR·x1`, `w2 += LR·x2`, `b += LR`.
  - Update on `err = −1`: the same terms are subtracted.
  - When `err ≠ 0`, the epoch error flag is set.
  - Each update saturates to [−32768, 32767] and never wraps.
- End of epoch, evaluated in the `i = 3` cycle and including that sample's error:
  - Flag clear → DONE with `converged = 1`; `epoch` is unchanged.
  - Flag set and `epoch == MAX_EPOCHS−1` → DONE with `converged = 0`; `epoch` is unchanged.
  - Otherwise `epoch` increments, the flag clears, `i` wraps to 0, and TRAIN continues.
- `start` asserted during TRAIN is ignored.
- Weights remain stable through DONE and IDLE.

## Timing

- Reset values (the same whenever `rst` is sampled high, including mid-TRAIN):
  - state = IDLE;
  - `busy`, `done`, `converged` = 0;
  - `w1`, `w2`, `b` = 0;
  - `epoch` = 0.
- `rst` has priority over `start`.
- If `start` is sampled at edge N, `busy` is high from N+1.
- Weight updates for sample `i` appear on the edge that ends that sample's cycle.
- For convergence in epoch E:
  - the final TRAIN cycle is N+4(E+1);
  - `done` rises at edge N+4(E+1), in the same edge that `busy` falls.
- Worst case (no convergence): `done` at N+4·MAX_EPOCHS.
- `converged` and `epoch` are valid on the first `done` cycle.
- `converged` clears on the next accepted `start`.

## Test plan

- **Reset:** assert `rst` for 2 cycles → `busy = done = converged = 0`, `w1 = w2 = b = 0`, `epoch = 0`.
- **AND** (`target = 4'b1000`, LR = 16): `start` → `done` 24 cycles later with `converged = 1`, `epoch = 5`, `w1 = 32`, `w2 = 16`, `b = −32`.
- **OR** (`target = 4'b1110`): `done` after 16 cycles with `converged = 1`, `epoch = 3`, `w1 = 16`, `w2 = 16`, `b = 0`.
- **XOR** (`target = 4'b0110`, MAX_EPOCHS = 32): `done` after 128 cycles with `converged = 0`, `epoch = 31`; `busy` high throughout.
- **Robustness:**
  - pulse `start` mid-TRAIN → no effect;
  - change `target` mid-TRAIN → AND result unchanged;
  - assert `rst` at cycle 10 → all outputs return to reset values on the next cycle;
  - re-`start` from DONE → a fresh run from zero weights.
- **Saturation:** LR = 16'sd16384 with XOR → `w1`, `w2`, `b` stay within [−32768, 32767] with no sign flip from overflow; a checker compares every update against a saturating reference model.
